// File: rtl/wb_commit_monitor_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : wb_monitor_pkg                                         |
// | Description : Shared types and widths for the write-back commit      |
// |               monitor (commit entry layout, halt FSM states).        |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
package wb_monitor_pkg;

  // Register data / PC width and destination index width of a commit entry
  localparam int MON_DATA_W = 32;
  localparam int MON_REG_W  = 5;

  // One recorded register-file commit
  typedef struct packed {
    logic [MON_DATA_W-1:0] pc;
    logic [MON_REG_W-1:0]  dest;
    logic [MON_DATA_W-1:0] data;
  } commit_entry_t;

  // Branch-to-self halt detector states
  typedef enum logic [1:0] {
    RUN     = 2'd0,
    SUSPECT = 2'd1,
    HALTED  = 2'd2
  } mon_state_e;

endpackage : wb_monitor_pkg
`default_nettype wire

// File: rtl/wb_commit_monitor_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : wb_commit_monitor_if                                   |
// | Description : Write-back tap and FWFT pop port of the commit monitor.|
// |               master = core/host side, slave = monitor side.         |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
interface wb_commit_monitor_if
  import wb_monitor_pkg::*;
#(
  parameter int DATA_W = MON_DATA_W,
  parameter int REG_W  = MON_REG_W
);
  // Write-back stage tap
  logic              wb_valid;
  logic              wb_wr_en;
  logic [REG_W-1:0]  wb_dest;
  logic [DATA_W-1:0] wb_data;
  logic [DATA_W-1:0] wb_pc;

  // Pop port
  logic              rd_ready;
  logic              rd_valid;
  logic [DATA_W-1:0] rd_pc;
  logic [REG_W-1:0]  rd_dest;
  logic [DATA_W-1:0] rd_data;

  modport master (
    output wb_valid, wb_wr_en, wb_dest, wb_data, wb_pc, rd_ready,
    input  rd_valid, rd_pc, rd_dest, rd_data
  );

  modport slave (
    input  wb_valid, wb_wr_en, wb_dest, wb_data, wb_pc, rd_ready,
    output rd_valid, rd_pc, rd_dest, rd_data
  );

endinterface : wb_commit_monitor_if
`default_nettype wire

// File: rtl/wb_commit_monitor_commit_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : commit_fifo                                            |
// | Description : First-word-fall-through synchronous FIFO of commit     |
// |               entries. Pointers carry a wrap bit to tell full from   |
// |               empty. Head reads as zero while empty.                 |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module commit_fifo
  import wb_monitor_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  wire logic          clk,
  input  wire logic          rst,
  input  wire logic          push,
  input  wire logic          pop,
  input  commit_entry_t      wr_entry,
  output commit_entry_t      rd_entry,
  output logic               full,
  output logic               empty
);

  localparam int           AW      = $clog2(DEPTH);
  localparam logic [AW:0]  PTR_ONE = {{AW{1'b0}}, 1'b1};

  commit_entry_t mem [DEPTH];
  logic [AW:0]   wr_ptr;
  logic [AW:0]   rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  // Pops on an empty FIFO are ignored; a full FIFO still accepts a push
  // when the head leaves in the same cycle.
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  // Head falls through from storage; zero when nothing is queued
  assign rd_entry = empty ? '0 : mem[rd_ptr[AW-1:0]];

  // Pointer update; reset discards all contents at once
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  // Entry storage, no reset needed since the head is masked while empty
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wr_entry;
  end

endmodule : commit_fifo
`default_nettype wire

// File: rtl/wb_commit_monitor.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : wb_commit_monitor                                      |
// | Description : Records register-file commits from the WB stage into   |
// |               a FWFT FIFO, keeps saturating retire/cycle/drop        |
// |               counters and detects the branch-to-self halt idiom.    |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module wb_commit_monitor
  import wb_monitor_pkg::*;
#(
  parameter int DATA_W      = MON_DATA_W,
  parameter int REG_W       = MON_REG_W,
  parameter int DEPTH       = 16,
  parameter int HALT_REPEAT = 4,
  parameter int CNT_W       = 32
) (
  input  wire logic          clk,
  input  wire logic          rst,
  wb_commit_monitor_if.slave bus,
  output logic [CNT_W-1:0]   retired_count,
  output logic [CNT_W-1:0]   cycle_count,
  output logic [CNT_W-1:0]   drop_count,
  output logic               overflow,
  output logic               halted
);

  localparam int               RW        = $clog2(HALT_REPEAT) + 1;
  localparam logic [RW-1:0]    RPT_ONE   = {{(RW-1){1'b0}}, 1'b1};
  localparam logic [RW-1:0]    RPT_LIMIT = RW'(HALT_REPEAT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};

  mon_state_e        state, state_nxt;
  logic [DATA_W-1:0] last_pc, last_pc_nxt;
  logic [RW-1:0]     repeat_q, repeat_nxt;
  logic [REG_W-1:0]  wb_dest_w;
  logic              same_pc;

  logic              push_req;
  logic              pop_req;
  logic              drop;
  logic              fifo_full;
  logic              fifo_empty;
  commit_entry_t     push_entry;
  commit_entry_t     head_entry;

  assign halted    = (state == HALTED);
  assign wb_dest_w = bus.wb_dest;
  assign same_pc   = (bus.wb_pc == last_pc);

  // Only real register writes are recorded; r0 is architecturally discarded
  assign push_req = bus.wb_valid & bus.wb_wr_en & (wb_dest_w != '0) & ~halted;
  assign pop_req  = bus.rd_ready & ~fifo_empty;
  assign drop     = push_req & fifo_full & ~pop_req;

  assign push_entry.pc   = bus.wb_pc;
  assign push_entry.dest = bus.wb_dest;
  assign push_entry.data = bus.wb_data;

  commit_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (push_req),
    .pop      (pop_req),
    .wr_entry (push_entry),
    .rd_entry (head_entry),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  assign bus.rd_valid = ~fifo_empty;
  assign bus.rd_pc    = head_entry.pc;
  assign bus.rd_dest  = head_entry.dest;
  assign bus.rd_data  = head_entry.data;

  // Halt detector state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= RUN;
      last_pc  <= '0;
      repeat_q <= '0;
    end else begin
      state    <= state_nxt;
      last_pc  <= last_pc_nxt;
      repeat_q <= repeat_nxt;
    end
  end

  // Halt detector next state: count back-to-back retirements at one PC
  always_comb begin
    state_nxt   = state;
    last_pc_nxt = last_pc;
    repeat_nxt  = repeat_q;
    case (state)
      RUN: begin
        if (bus.wb_valid) begin
          last_pc_nxt = bus.wb_pc;
          if (same_pc) begin
            repeat_nxt = RPT_ONE;
            state_nxt  = (RPT_LIMIT == RPT_ONE) ? HALTED : SUSPECT;
          end
        end
      end
      SUSPECT: begin
        if (bus.wb_valid) begin
          last_pc_nxt = bus.wb_pc;
          if (same_pc) begin
            repeat_nxt = repeat_q + RPT_ONE;
            if ((repeat_q + RPT_ONE) == RPT_LIMIT) state_nxt = HALTED;
          end else begin
            repeat_nxt = '0;
            state_nxt  = RUN;
          end
        end
      end
      HALTED: begin
        state_nxt = HALTED;
      end
      default: begin
        state_nxt  = RUN;
        repeat_nxt = '0;
      end
    endcase
  end

  // Saturating statistics, frozen once halted
  always_ff @(posedge clk) begin
    if (rst) begin
      retired_count <= '0;
      cycle_count   <= '0;
      drop_count    <= '0;
      overflow      <= 1'b0;
    end else if (!halted) begin
      if (cycle_count != '1) cycle_count <= cycle_count + CNT_ONE;
      if (bus.wb_valid && (retired_count != '1)) retired_count <= retired_count + CNT_ONE;
      if (drop) begin
        overflow <= 1'b1;
        if (drop_count != '1) drop_count <= drop_count + CNT_ONE;
      end
    end
  end

endmodule : wb_commit_monitor
`default_nettype wire

// File: tb/tb_wb_commit_monitor.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : tb_wb_commit_monitor                                   |
// | Description : Directed self-checking bench for wb_commit_monitor     |
// |               with a queue-based reference model.                    |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module tb_wb_commit_monitor;

  localparam int DEPTH       = 16;
  localparam int HALT_REPEAT = 4;

  typedef struct {
    logic [31:0] pc;
    logic [4:0]  dest;
    logic [31:0] data;
  } ent_t;

  logic clk = 1'b0;
  logic rst;
  logic [31:0] retired_count, cycle_count, drop_count;
  logic overflow, halted;

  wb_commit_monitor_if bus ();

  wb_commit_monitor #(
    .DEPTH       (DEPTH),
    .HALT_REPEAT (HALT_REPEAT),
    .CNT_W       (32)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .bus           (bus),
    .retired_count (retired_count),
    .cycle_count   (cycle_count),
    .drop_count    (drop_count),
    .overflow      (overflow),
    .halted        (halted)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  // Reference model state
  ent_t        q[$];
  logic [31:0] m_ret, m_cyc, m_drop, m_last_pc;
  logic        m_ovf, m_halt;
  int          m_streak;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Apply one clock edge to the model using the inputs presented at that edge
  task automatic model_edge();
    bit   pop, push;
    ent_t e;
    if (rst) begin
      q.delete();
      m_ret = 0; m_cyc = 0; m_drop = 0; m_ovf = 0; m_halt = 0;
      m_last_pc = 0; m_streak = 1;
    end else begin
      pop  = (q.size() > 0) && bus.rd_ready;
      push = bus.wb_valid && bus.wb_wr_en && (bus.wb_dest != 0) && !m_halt;
      if (pop) void'(q.pop_front());
      if (push) begin
        if (q.size() < DEPTH) begin
          e.pc = bus.wb_pc; e.dest = bus.wb_dest; e.data = bus.wb_data;
          q.push_back(e);
        end else begin
          if (m_drop != 32'hFFFF_FFFF) m_drop++;
          m_ovf = 1;
        end
      end
      if (!m_halt) begin
        if (m_cyc != 32'hFFFF_FFFF) m_cyc++;
        if (bus.wb_valid) begin
          if (m_ret != 32'hFFFF_FFFF) m_ret++;
          m_streak  = (bus.wb_pc == m_last_pc) ? m_streak + 1 : 1;
          m_last_pc = bus.wb_pc;
          if (m_streak >= HALT_REPEAT) m_halt = 1;
        end
      end
    end
  endtask

  task automatic cyc(input logic v, input logic w, input logic [4:0] d,
                     input logic [31:0] dat, input logic [31:0] pc, input logic rdy);
    bus.wb_valid = v; bus.wb_wr_en = w; bus.wb_dest = d;
    bus.wb_data = dat; bus.wb_pc = pc; bus.rd_ready = rdy;
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle(input logic rdy);
    cyc(1'b0, 1'b0, 5'd0, 32'd0, 32'd0, rdy);
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    repeat (3) idle(1'b0);
    rst = 1'b0;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_rd_valid"}, bus.rd_valid, 0);
    check({tag, "_retired"}, retired_count, 0);
    check({tag, "_cycle"}, cycle_count, 0);
    check({tag, "_drop"}, drop_count, 0);
    check({tag, "_overflow"}, overflow, 0);
    check({tag, "_halted"}, halted, 0);
  endtask

  // Per-cycle comparison against the model, away from the active edge
  always @(negedge clk) begin
    if (chk_en) begin
      check("cyc_rd_valid", bus.rd_valid, (q.size() > 0));
      if (q.size() > 0) begin
        check("cyc_rd_pc", bus.rd_pc, q[0].pc);
        check("cyc_rd_dest", bus.rd_dest, q[0].dest);
        check("cyc_rd_data", bus.rd_data, q[0].data);
      end else begin
        check("cyc_rd_zero", {bus.rd_pc, bus.rd_dest, bus.rd_data}, 0);
      end
      check("cyc_retired", retired_count, m_ret);
      check("cyc_cycle", cycle_count, m_cyc);
      check("cyc_drop", drop_count, m_drop);
      check("cyc_overflow", overflow, m_ovf);
      check("cyc_halted", halted, m_halt);
    end
  end

  initial begin
    int n;
    logic [31:0] halt_pcs [6];
    logic [31:0] brk_pcs  [7];
    halt_pcs = '{32'h20, 32'h24, 32'h24, 32'h24, 32'h24, 32'h24};
    brk_pcs  = '{32'h24, 32'h24, 32'h24, 32'h28, 32'h24, 32'h24, 32'h24};
    rst = 1'b1;
    bus.wb_valid = 0; bus.wb_wr_en = 0; bus.wb_dest = 0;
    bus.wb_data = 0; bus.wb_pc = 0; bus.rd_ready = 0;

    // Reset values
    reset_dut();
    chk_en = 1'b1;
    check_reset_values("reset");

    // Basic commits, r0 write not recorded
    cyc(1, 1, 5'd3, 32'hDEAD, 32'h10, 0);
    cyc(1, 1, 5'd0, 32'h1,    32'h14, 0);
    cyc(1, 1, 5'd7, 32'hBEEF, 32'h18, 0);
    check("basic_retired", retired_count, 3);
    check("basic_head0", {bus.rd_valid, bus.rd_pc, bus.rd_dest, bus.rd_data},
          {1'b1, 32'h10, 5'd3, 32'hDEAD});
    idle(1);
    check("basic_head1", {bus.rd_valid, bus.rd_pc, bus.rd_dest, bus.rd_data},
          {1'b1, 32'h18, 5'd7, 32'hBEEF});
    idle(1);
    check("basic_empty", bus.rd_valid, 0);
    idle(1);
    check("basic_empty_pop", bus.rd_valid, 0);

    // Overflow: 18 pushes into 16 entries
    reset_dut();
    for (int i = 0; i < 18; i++)
      cyc(1, 1, 5'((i % 31) + 1), 32'(i * 17 + 1), 32'h100 + 32'(4 * i), 0);
    check("ovf_drop", drop_count, 2);
    check("ovf_flag", overflow, 1);

    // Full with simultaneous pop: accepted, lands at the tail
    cyc(1, 1, 5'd9, 32'h5A5A, 32'h900, 1);
    check("fullpop_drop", drop_count, 2);
    for (int k = 1; k < 16; k++) begin
      check("drain_pc", bus.rd_pc, 32'h100 + 32'(4 * k));
      idle(1);
    end
    check("drain_last", {bus.rd_pc, bus.rd_data}, {32'h900, 32'h5A5A});
    idle(1);
    check("drain_empty", bus.rd_valid, 0);

    // Reset with entries queued discards them
    cyc(1, 1, 5'd1, 32'h1, 32'h300, 0);
    cyc(1, 1, 5'd2, 32'h2, 32'h304, 0);
    reset_dut();
    check_reset_values("midreset");

    // Halt detection
    for (int i = 0; i < 6; i++) begin
      cyc(1, 1, 5'd5, 32'(i), halt_pcs[i], 0);
      if (i == 3) check("halt_not_yet", halted, 0);
      if (i == 4) begin
        check("halt_set", halted, 1);
        check("halt_retired", retired_count, 5);
      end
    end
    check("halt_retired_frozen", retired_count, 5);
    repeat (3) idle(0);
    check("halt_still", halted, 1);
    n = 0;
    for (int k = 0; k < 20; k++) begin
      if (!bus.rd_valid) break;
      n++;
      idle(1);
    end
    check("halt_pushed_entries", n, 5);

    // Recovery via reset pulse while halted
    rst = 1'b1;
    idle(0);
    rst = 1'b0;
    check_reset_values("recover");

    // Broken repeat sequence never halts
    for (int i = 0; i < 7; i++) cyc(1, 1, 5'd6, 32'(i), brk_pcs[i], 1);
    check("broken_halted", halted, 0);
    check("broken_retired", retired_count, 7);
    repeat (2) idle(1);

    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule : tb_wb_commit_monitor
`default_nettype wire
